// File: rtl/tunable_dds_axil_regs_pkg.sv
// Shared constants and types for the tunable DDS AXI4-Lite register block.
// Optional slave-error decode is enabled by the TUNABLE_DDS_AXIL_SLVERR_EN macro.
package tunable_dds_pkg;

   typedef logic [1:0] regIdx_t;

   localparam regIdx_t REG_CTRL = 2'd0;
   localparam regIdx_t REG_FTW  = 2'd1;
   localparam regIdx_t REG_POFF = 2'd2;
   localparam regIdx_t REG_AMPL = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_AW,
      WR_HAVE_W,
      WR_RESP
   } wrState_t;

   // Byte-lane merge: only lanes with their strobe set take the new byte.
   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = oldVal;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = newVal[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tunable_dds_axil_regs_if.sv
// AXI4-Lite bundle for the DDS control port; master drives requests, slave answers.
// Used by the TUNABLE_DDS_AXIL_SLVERR_EN-configurable register block.
interface tunable_dds_axil_regs_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/tunable_dds_axil_regs_wr_ctrl.sv
// Write-side controller: buffers whichever of AW/W arrives first, commits when both are
// present, then holds the B response. SLVERR decode under TUNABLE_DDS_AXIL_SLVERR_EN.
module tunable_dds_axil_wr_ctrl
   import tunable_dds_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] awAddr_i,
   input  logic                  awValid_i,
   output logic                  awReady_o,
   input  logic [31:0]           wData_i,
   input  logic [3:0]            wStrb_i,
   input  logic                  wValid_i,
   output logic                  wReady_o,
   output logic                  bValid_o,
   output logic [1:0]            bResp_o,
   input  logic                  bReady_i,
   output logic                  wrEn_o,
   output regIdx_t               wrIdx_o,
   output logic [31:0]           wrData_o,
   output logic [3:0]            wrStrb_o,
   output logic                  cfgUpdate_o
);

   wrState_t              state_q, state_d;
   logic [ADDR_WIDTH-1:0] awAddr_q;
   logic [31:0]           wData_q;
   logic [3:0]            wStrb_q;
   logic [1:0]            bResp_q;
   logic                  cfgUpdate_q;

   logic                  awFire, wFire, haveAw, haveW, commit;
   logic                  addrErr, upperNonZero;
   logic [ADDR_WIDTH-1:0] curAddr;
   logic                  unusedAddrBits;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= WR_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Readies are held low while reset is asserted so no beat is accepted then.
   always_comb begin
      state_d   = state_q;
      awReady_o = 1'b0;
      wReady_o  = 1'b0;
      bValid_o  = 1'b0;
      case (state_q)
         WR_IDLE: begin
            awReady_o = !rst_i;
            wReady_o  = !rst_i;
         end
         WR_HAVE_AW: wReady_o  = !rst_i;
         WR_HAVE_W:  awReady_o = !rst_i;
         WR_RESP:    bValid_o  = 1'b1;
         default: ;
      endcase
      awFire = awValid_i & awReady_o;
      wFire  = wValid_i & wReady_o;
      haveAw = awFire | (state_q == WR_HAVE_AW);
      haveW  = wFire | (state_q == WR_HAVE_W);
      commit = haveAw & haveW;
      case (state_q)
         WR_IDLE: begin
            if (commit)      state_d = WR_RESP;
            else if (awFire) state_d = WR_HAVE_AW;
            else if (wFire)  state_d = WR_HAVE_W;
         end
         WR_HAVE_AW: if (wFire)    state_d = WR_RESP;
         WR_HAVE_W:  if (awFire)   state_d = WR_RESP;
         WR_RESP:    if (bReady_i) state_d = WR_IDLE;
         default:    state_d = WR_IDLE;
      endcase
   end

   assign curAddr      = (state_q == WR_HAVE_AW) ? awAddr_q : awAddr_i;
   assign upperNonZero = (curAddr >> 4) != '0;

`ifdef TUNABLE_DDS_AXIL_SLVERR_EN
   assign addrErr = upperNonZero;
`else
   assign addrErr = 1'b0;
`endif

   assign unusedAddrBits = ^{curAddr[1:0], upperNonZero};

   // Beat buffers and the registered response/strobe that appear one cycle after commit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         awAddr_q    <= '0;
         wData_q     <= '0;
         wStrb_q     <= '0;
         bResp_q     <= RESP_OKAY;
         cfgUpdate_q <= 1'b0;
      end else begin
         if (awFire) awAddr_q <= awAddr_i;
         if (wFire) begin
            wData_q <= wData_i;
            wStrb_q <= wStrb_i;
         end
         if (commit) bResp_q <= addrErr ? RESP_SLVERR : RESP_OKAY;
         cfgUpdate_q <= commit & !addrErr;
      end
   end

   assign wrEn_o      = commit & !addrErr;
   assign wrIdx_o     = curAddr[3:2];
   assign wrData_o    = (state_q == WR_HAVE_W) ? wData_q : wData_i;
   assign wrStrb_o    = (state_q == WR_HAVE_W) ? wStrb_q : wStrb_i;
   assign bResp_o     = bResp_q;
   assign cfgUpdate_o = cfgUpdate_q;

endmodule

// File: rtl/tunable_dds_axil_regs.sv
// AXI4-Lite register file driving the DDS core: enable, tuning word, phase offset, amplitude.
// Out-of-range addresses return SLVERR when TUNABLE_DDS_AXIL_SLVERR_EN is defined.
module tunable_dds_axil_regs
   import tunable_dds_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int AMPL_WIDTH         = 16
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   tunable_dds_axil_regs_if.slave        s_axi,
   output logic                          dds_enable,
   output logic [C_S_AXI_DATA_WIDTH-1:0] dds_phase_inc,
   output logic [C_S_AXI_DATA_WIDTH-1:0] dds_phase_off,
   output logic [AMPL_WIDTH-1:0]         dds_ampl,
   output logic                          cfg_update
);

   logic [C_S_AXI_DATA_WIDTH-1:0] regFile_q [4];

   logic        awReady, wReady, bValid, wrEn, cfgUpdate;
   logic [1:0]  bResp;
   regIdx_t     wrIdx;
   logic [31:0] wrData;
   logic [3:0]  wrStrb;

   logic                          rValid_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rData_q;
   logic [1:0]                    rResp_q;
   logic                          arReady, arFire, rdErr, arUpperNonZero;
   regIdx_t                       arIdx;
   logic                          unusedTopBits;

   tunable_dds_axil_wr_ctrl #(
      .ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)
   ) u_wrCtrl (
      .clk_i      (S_AXI_ACLK),
      .rst_i      (S_AXI_ARESET),
      .awAddr_i   (s_axi.awaddr),
      .awValid_i  (s_axi.awvalid),
      .awReady_o  (awReady),
      .wData_i    (s_axi.wdata),
      .wStrb_i    (s_axi.wstrb),
      .wValid_i   (s_axi.wvalid),
      .wReady_o   (wReady),
      .bValid_o   (bValid),
      .bResp_o    (bResp),
      .bReady_i   (s_axi.bready),
      .wrEn_o     (wrEn),
      .wrIdx_o    (wrIdx),
      .wrData_o   (wrData),
      .wrStrb_o   (wrStrb),
      .cfgUpdate_o(cfgUpdate)
   );

   assign s_axi.awready = awReady;
   assign s_axi.wready  = wReady;
   assign s_axi.bvalid  = bValid;
   assign s_axi.bresp   = bResp;
   assign cfg_update    = cfgUpdate;

   // Register storage; a read in the same cycle as a write still sees the old value.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < 4; i++) begin
            regFile_q[i] <= '0;
         end
      end else if (wrEn) begin
         regFile_q[wrIdx] <= mergeBytes(regFile_q[wrIdx], wrData, wrStrb);
      end
   end

   assign arReady        = !rValid_q && !S_AXI_ARESET;
   assign arFire         = s_axi.arvalid & arReady;
   assign arIdx          = s_axi.araddr[3:2];
   assign arUpperNonZero = (s_axi.araddr >> 4) != '0;

`ifdef TUNABLE_DDS_AXIL_SLVERR_EN
   assign rdErr = arUpperNonZero;
`else
   assign rdErr = 1'b0;
`endif

   assign unusedTopBits = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], arUpperNonZero};

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         rValid_q <= 1'b0;
         rData_q  <= '0;
         rResp_q  <= RESP_OKAY;
      end else if (arFire) begin
         rValid_q <= 1'b1;
         rData_q  <= rdErr ? '0 : regFile_q[arIdx];
         rResp_q  <= rdErr ? RESP_SLVERR : RESP_OKAY;
      end else if (rValid_q && s_axi.rready) begin
         rValid_q <= 1'b0;
      end
   end

   assign s_axi.arready = arReady;
   assign s_axi.rvalid  = rValid_q;
   assign s_axi.rdata   = rData_q;
   assign s_axi.rresp   = rResp_q;

   assign dds_enable    = regFile_q[REG_CTRL][0];
   assign dds_phase_inc = regFile_q[REG_FTW];
   assign dds_phase_off = regFile_q[REG_POFF];
   assign dds_ampl      = regFile_q[REG_AMPL][AMPL_WIDTH-1:0];

endmodule

// File: tb/tb_tunable_dds_axil_regs.sv
// Directed plus randomized bench for the DDS AXI4-Lite register file, checked against
// a byte-mask register model. Default build (TUNABLE_DDS_AXIL_SLVERR_EN undefined).
module tb_tunable_dds_axil_regs;

   localparam int AW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ddsEnable;
   logic [31:0] ddsPhaseInc, ddsPhaseOff;
   logic [15:0] ddsAmpl;
   logic        cfgUpdate;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model [4];

   always #5 clk = ~clk;

   tunable_dds_axil_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) axi ();

   tunable_dds_axil_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(AW),
      .AMPL_WIDTH        (16)
   ) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (axi),
      .dds_enable   (ddsEnable),
      .dds_phase_inc(ddsPhaseInc),
      .dds_phase_off(ddsPhaseOff),
      .dds_ampl     (ddsAmpl),
      .cfg_update   (cfgUpdate)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference write: bytes with their strobe set are replaced, others kept.
   task automatic modelWrite(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      model[addr[3:2]] = (model[addr[3:2]] & ~mask) | (data & mask);
   endtask

   task automatic checkDds();
      checkOutput("dds_enable", {31'b0, ddsEnable}, {31'b0, model[0][0]});
      checkOutput("dds_phase_inc", ddsPhaseInc, model[1]);
      checkOutput("dds_phase_off", ddsPhaseOff, model[2]);
      checkOutput("dds_ampl", {16'b0, ddsAmpl}, {16'b0, model[3][15:0]});
   endtask

   task automatic axiWrite(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awDly, input int wDly, input int bDly);
      bit awDone = 0;
      bit wDone  = 0;
      int cyc    = 0;
      while (!(awDone && wDone) && cyc < 40) begin
         @(negedge clk);
         checkOutput("bvalid_before_commit", {31'b0, axi.bvalid}, 32'd0);
         checkOutput("cfg_before_commit", {31'b0, cfgUpdate}, 32'd0);
         axi.awaddr  = addr;
         axi.wdata   = data;
         axi.wstrb   = strb;
         axi.awvalid = !awDone && (cyc >= awDly);
         axi.wvalid  = !wDone && (cyc >= wDly);
         if (axi.awvalid && axi.awready) awDone = 1;
         if (axi.wvalid && axi.wready) wDone = 1;
         cyc++;
      end
      checkOutput("wr_handshake_done", {31'b0, awDone & wDone}, 32'd1);
      @(negedge clk);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      modelWrite(addr, data, strb);
      checkOutput("bvalid", {31'b0, axi.bvalid}, 32'd1);
      checkOutput("bresp", {30'b0, axi.bresp}, 32'd0);
      checkOutput("cfg_update_pulse", {31'b0, cfgUpdate}, 32'd1);
      checkDds();
      for (int i = 0; i < bDly; i++) begin
         checkOutput("awready_while_bvalid", {31'b0, axi.awready}, 32'd0);
         checkOutput("wready_while_bvalid", {31'b0, axi.wready}, 32'd0);
         @(negedge clk);
         checkOutput("bvalid_hold", {31'b0, axi.bvalid}, 32'd1);
         checkOutput("cfg_single_pulse", {31'b0, cfgUpdate}, 32'd0);
      end
      axi.bready = 1'b1;
      @(negedge clk);
      axi.bready = 1'b0;
      checkOutput("bvalid_cleared", {31'b0, axi.bvalid}, 32'd0);
      checkOutput("awready_back", {31'b0, axi.awready}, 32'd1);
      checkOutput("wready_back", {31'b0, axi.wready}, 32'd1);
      checkOutput("cfg_after_b", {31'b0, cfgUpdate}, 32'd0);
   endtask

   task automatic axiRead(input logic [AW-1:0] addr, input int arDly, input int rDly, input logic [31:0] exp);
      logic [31:0] held;
      for (int i = 0; i < arDly; i++) @(negedge clk);
      @(negedge clk);
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      checkOutput("arready_idle", {31'b0, axi.arready}, 32'd1);
      @(negedge clk);
      axi.arvalid = 1'b0;
      checkOutput("rvalid", {31'b0, axi.rvalid}, 32'd1);
      checkOutput("rresp", {30'b0, axi.rresp}, 32'd0);
      checkOutput("rdata", axi.rdata, exp);
      held = exp;
      for (int i = 0; i < rDly; i++) begin
         checkOutput("arready_while_rvalid", {31'b0, axi.arready}, 32'd0);
         @(negedge clk);
         checkOutput("rvalid_hold", {31'b0, axi.rvalid}, 32'd1);
         checkOutput("rdata_stable", axi.rdata, held);
      end
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;
      checkOutput("rvalid_cleared", {31'b0, axi.rvalid}, 32'd0);
      checkOutput("arready_back", {31'b0, axi.arready}, 32'd1);
   endtask

   // Randomized writes with random handshake ordering, each followed by a random readback.
   task automatic applyStimulus(input int count);
      logic [AW-1:0] wa, ra;
      logic [31:0]   wd;
      logic [3:0]    ws;
      for (int n = 0; n < count; n++) begin
         wa = AW'($urandom_range(0, 15));
         wd = $urandom;
         ws = 4'($urandom_range(0, 15));
         axiWrite(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         ra = AW'($urandom_range(0, 15));
         axiRead(ra, $urandom_range(0, 1), $urandom_range(0, 2), model[ra[3:2]]);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 4; i++) model[i] = 32'd0;
      axi.awaddr = '0; axi.awprot = 3'b0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.araddr = '0; axi.arprot = 3'b0; axi.arvalid = 1'b0; axi.rready = 1'b0;

      $display("[TB] reset state");
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_awready", {31'b0, axi.awready}, 32'd0);
      checkOutput("rst_wready", {31'b0, axi.wready}, 32'd0);
      checkOutput("rst_arready", {31'b0, axi.arready}, 32'd0);
      checkOutput("rst_bvalid", {31'b0, axi.bvalid}, 32'd0);
      checkOutput("rst_rvalid", {31'b0, axi.rvalid}, 32'd0);
      checkOutput("rst_rdata", axi.rdata, 32'd0);
      checkOutput("rst_cfg", {31'b0, cfgUpdate}, 32'd0);
      checkDds();
      rst = 1'b0;

      $display("[TB] sequential writes and reads");
      for (int i = 0; i < 4; i++) axiWrite(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) axiRead(AW'(4 * i), 0, 0, model[i]);
      checkOutput("seq_enable", {31'b0, ddsEnable}, 32'd1);
      checkOutput("seq_phase_inc", ddsPhaseInc, 32'd2);
      checkOutput("seq_ampl", {16'b0, ddsAmpl}, 32'h0000_0004);

      $display("[TB] byte strobes");
      axiWrite(4'h4, 32'hDEADBEEF, 4'b0101, 0, 0, 0);
      axiRead(4'h4, 0, 0, model[1]);
      checkOutput("strobe_expected", model[1], 32'h00AD00EF);

      $display("[TB] AW/W ordering and B backpressure");
      axiWrite(4'h8, 32'h1234_5678, 4'hF, 0, 3, 0);
      axiWrite(4'hC, 32'hCAFE_0A0A, 4'hF, 2, 0, 5);
      axiRead(4'h8, 0, 0, model[2]);
      axiRead(4'hC, 0, 0, model[3]);

      $display("[TB] same-cycle read and write, R backpressure");
      axiWrite(4'h8, 32'h11, 4'hF, 0, 0, 0);
      @(negedge clk);
      axi.araddr = 4'h8; axi.arvalid = 1'b1;
      axi.awaddr = 4'h8; axi.awvalid = 1'b1;
      axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      checkOutput("same_arready", {31'b0, axi.arready}, 32'd1);
      checkOutput("same_awready", {31'b0, axi.awready}, 32'd1);
      checkOutput("same_wready", {31'b0, axi.wready}, 32'd1);
      @(negedge clk);
      axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      checkOutput("same_rvalid", {31'b0, axi.rvalid}, 32'd1);
      checkOutput("same_rdata_old", axi.rdata, 32'h11);
      checkOutput("same_bvalid", {31'b0, axi.bvalid}, 32'd1);
      modelWrite(4'h8, 32'h55, 4'hF);
      checkDds();
      axi.bready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("same_arready_hold", {31'b0, axi.arready}, 32'd0);
         @(negedge clk);
         axi.bready = 1'b0;
         checkOutput("same_rvalid_hold", {31'b0, axi.rvalid}, 32'd1);
         checkOutput("same_rdata_hold", axi.rdata, 32'h11);
      end
      checkOutput("same_bvalid_done", {31'b0, axi.bvalid}, 32'd0);
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;
      checkOutput("same_rvalid_done", {31'b0, axi.rvalid}, 32'd0);
      axiRead(4'h8, 0, 0, model[2]);

      $display("[TB] randomized traffic");
      applyStimulus(24);

      $display("[TB] reset with AW buffered");
      @(negedge clk);
      axi.awaddr = 4'h4; axi.awvalid = 1'b1;
      checkOutput("mid_awready", {31'b0, axi.awready}, 32'd1);
      @(negedge clk);
      axi.awvalid = 1'b0;
      checkOutput("mid_wready_pending", {31'b0, axi.wready}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) model[i] = 32'd0;
      checkOutput("mid_rst_awready", {31'b0, axi.awready}, 32'd0);
      checkOutput("mid_rst_wready", {31'b0, axi.wready}, 32'd0);
      checkOutput("mid_rst_bvalid", {31'b0, axi.bvalid}, 32'd0);
      checkOutput("mid_rst_rdata", axi.rdata, 32'd0);
      checkDds();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("post_rst_no_bvalid", {31'b0, axi.bvalid}, 32'd0);
         checkOutput("post_rst_awready", {31'b0, axi.awready}, 32'd1);
         checkOutput("post_rst_wready", {31'b0, axi.wready}, 32'd1);
      end
      v = $urandom;
      axiWrite(4'hC, v, 4'hF, 1, 0, 1);
      axiRead(4'hC, 0, 1, model[3]);
      axiRead(4'h4, 0, 0, model[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tunable_dds_axil_regs.md
Name: tunable_dds_axil_regs

Overview:
- AXI4-Lite slave (responder) register file for the tunable DDS. It serves the S00_AXI control port that the master VIP drives.
- Holds four 32-bit read/write configuration registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Drives the DDS core's enable, frequency tuning word, phase offset and amplitude, plus a one-cycle update strobe.
- Sits between the AXI interconnect and the phase-accumulator core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; must be 4 or more. Bits [3:2] select the register.
- AMPL_WIDTH, 16, width of the dds_ampl output, taken from the low bits of register 3.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH / S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- dds_enable  out  1  REG0[0].
- dds_phase_inc  out  32  REG1, frequency tuning word.
- dds_phase_off  out  32  REG2.
- dds_ampl  out  AMPL_WIDTH  REG3[AMPL_WIDTH-1:0].
- cfg_update  out  1  one-cycle pulse after any register write commits.

Behaviour:
- Reset (synchronous, S_AXI_ARESET=1 at an edge):
  - REG0..REG3 = 0.
  - All READY and VALID outputs = 0; BRESP = RRESP = 0; RDATA = 0; cfg_update = 0.
  - Any buffered AW or W beat is discarded.
  - Reset mid-transaction drops the transaction; no response is issued afterwards.
- Write channel:
  - AWREADY = 1 when no AW beat is buffered and BVALID = 0. WREADY = 1 when no W beat is buffered and BVALID = 0.
  - AW and W may complete in any order or in the same cycle; the first to arrive is buffered.
  - In the cycle k where both are available (buffered or handshaking), the write commits at the end of cycle k.
  - Byte lane n is updated only when WSTRB[n] = 1.
  - BVALID = 1 and cfg_update = 1 in cycle k+1.
  - BVALID holds until BREADY is sampled high. AWREADY and WREADY return high in the cycle after the B handshake.
  - Peak throughput is one write per 2 cycles.
- Read channel:
  - ARREADY = 1 when RVALID = 0.
  - An AR handshake in cycle k gives RVALID = 1 and RDATA = the register selected by ARADDR[3:2] in cycle k+1.
  - RDATA and RVALID are held stable until RREADY is sampled high. ARREADY returns high the cycle after the R handshake.
- Read and write channels are independent.
  - A read and a write to the same register in the same cycle: the read returns the pre-write value.
- Address decode:
  - ADDR[1:0] are ignored.
  - Address bits above [3:2] are ignored, so accesses alias, unless the optional feature is enabled.
  - BRESP and RRESP are OKAY (2'b00).
- DDS outputs are combinational copies of the registers. They update at the same edge the write commits.
- cfg_update pulses exactly once per committed write, even if WSTRB = 0.

Optional Feature:
- Macro: TUNABLE_DDS_AXIL_SLVERR_EN.
- Defined, with C_S_AXI_ADDR_WIDTH > 4: any access with nonzero address bits above bit 3 returns SLVERR (2'b10).
  - Such a write leaves no register modified and produces no cfg_update pulse.
  - Such a read returns RDATA = 0.
- Not defined: those accesses alias onto REG0..REG3 with OKAY.

Decomposition:
- Package tunable_dds_pkg holds:
  - register offset constants REG_CTRL = 0, REG_FTW = 1, REG_POFF = 2, REG_AMPL = 3;
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - the register-index typedef, logic [1:0].
- One natural sub-module: tunable_dds_axil_wr_ctrl, the AW/W buffering and B-response FSM. Register storage and the read path stay in the top.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same offsets -> each read returns the written value with RRESP = OKAY; dds_enable = 1, dds_phase_inc = 2, dds_ampl = 0x0004.
- Write 0xDEADBEEF with WSTRB = 4'b0101 to 0x4, which holds 0x00000002 -> readback is 0x00AD00EF; one cfg_update pulse.
- AWVALID 3 cycles before WVALID, then W before AW on a second write -> both commit; BVALID is asserted exactly 1 cycle after the later handshake.
- BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY stay 0 and no new write is accepted; readies rise the cycle after the B handshake.
- RREADY held low 4 cycles -> RDATA stable and ARREADY = 0 throughout; a same-cycle write of 0x55 to a register being read at 0x11 returns 0x11.
- S_AXI_ARESET pulsed while AW is buffered and W is pending -> outputs return to 0, no BVALID follows, and a subsequent write/read pair works normally.
